// File: rtl/uart_tx_scheduler_if.sv
// Handshake bundle between the byte producers, the shared UART transmitter and the scheduler.
// The scheduler takes the slave view; producers and transmitter together form the master view.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_busy;
    logic                      tx_done;
    logic [IDX_W-1:0]          grant_idx;
    logic                      active;
    logic                      timeout_err;

    modport master (
        output req, req_data, tx_busy, tx_done,
        input  ack, tx_start, tx_data, grant_idx, active, timeout_err
    );

    modport slave (
        input  req, req_data, tx_busy, tx_done,
        output ack, tx_start, tx_data, grant_idx, active, timeout_err
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers,
// with a watchdog that abandons a frame whose done pulse never arrives.
module uart_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 4095,
    parameter int CNT_W   = 12
) (
    input logic               clk,
    input logic               rst,
    uart_tx_scheduler_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               tx_start_q, tx_start_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic               active_q, active_d;
    logic               timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               found;
    logic [IDX_W-1:0]   win;

    // Search starts just after the last winner, so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && bus.req[IDX_W'((int'(last_q) + k) % NUM_REQ)]) begin
                found = 1'b1;
                win   = IDX_W'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        ack_d         = '0;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        grant_d       = grant_q;
        active_d      = active_q;
        timeout_err_d = 1'b0;
        cnt_d         = cnt_q;

        case (state_q)
            IDLE: begin
                if (found && !bus.tx_busy) begin
                    state_d    = LAUNCH;
                    ack_d[win] = 1'b1;
                    tx_start_d = 1'b1;
                    active_d   = 1'b1;
                    tx_data_d  = bus.req_data[int'(win)*DATA_W +: DATA_W];
                    grant_d    = win;
                    last_d     = win;
                end
            end
            LAUNCH: begin
                state_d = WAIT_DONE;
                cnt_d   = '0;
            end
            WAIT_DONE: begin
                if (bus.tx_done) begin
                    state_d  = IDLE;
                    active_d = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    // Aborted winner stays in last_q and therefore drops to lowest priority.
                    state_d       = IDLE;
                    active_d      = 1'b0;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            last_q        <= IDX_W'(NUM_REQ - 1);
            ack_q         <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            grant_q       <= '0;
            active_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            ack_q         <= ack_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            grant_q       <= grant_d;
            active_q      <= active_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.grant_idx   = grant_q;
    assign bus.active      = active_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: expected grants are queued when requests are
// driven and popped when the scheduler fires tx_start.
module tb_uart_tx_scheduler;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 4095;
    localparam int CNT_W   = 12;

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic saw;
    exp_t expQ[$];

    uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .DATA_W(DATA_W)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .DATA_W(DATA_W),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic busy);
        bus.req     = r;
        bus.tx_busy = busy;
    endtask

    task automatic setData(input int i, input logic [DATA_W-1:0] b);
        bus.req_data[i*DATA_W +: DATA_W] = b;
    endtask

    task automatic pushExp(input int i, input logic [DATA_W-1:0] b);
        exp_t e;
        e.idx  = IDX_W'(i);
        e.data = b;
        expQ.push_back(e);
    endtask

    // Waits up to budget cycles for tx_start, checks the launch cycle against the queue head,
    // drops the requester bits in dropMask during the ack cycle, then checks the pulses ended.
    task automatic expectGrant(input string tag, input int budget, input logic [NUM_REQ-1:0] dropMask);
        int   waited = 0;
        exp_t e;
        while (bus.tx_start !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
        if (bus.tx_start !== 1'b1) begin
            checkOutput({tag, " tx_start"}, 32'(bus.tx_start), 32'd1);
            return;
        end
        checkOutput({tag, " queued"}, 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() == 0) return;
        e = expQ.pop_front();
        checkOutput({tag, " grant_idx"}, 32'(bus.grant_idx), 32'(e.idx));
        checkOutput({tag, " tx_data"}, 32'(bus.tx_data), 32'(e.data));
        checkOutput({tag, " ack"}, 32'(bus.ack), 32'(1) << e.idx);
        checkOutput({tag, " active"}, 32'(bus.active), 32'd1);
        bus.req = bus.req & ~dropMask;
        tick();
        checkOutput({tag, " ack end"}, 32'(bus.ack), 32'd0);
        checkOutput({tag, " start end"}, 32'(bus.tx_start), 32'd0);
    endtask

    task automatic doneAfter(input string tag, input int n);
        repeat (n) tick();
        checkOutput({tag, " active before done"}, 32'(bus.active), 32'd1);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        checkOutput({tag, " active after done"}, 32'(bus.active), 32'd0);
    endtask

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        bus.tx_busy  = 1'b0;
        bus.tx_done  = 1'b0;

        tick();
        tick();
        checkOutput("reset ack", 32'(bus.ack), 32'd0);
        checkOutput("reset tx_start", 32'(bus.tx_start), 32'd0);
        checkOutput("reset tx_data", 32'(bus.tx_data), 32'd0);
        checkOutput("reset grant_idx", 32'(bus.grant_idx), 32'd0);
        checkOutput("reset active", 32'(bus.active), 32'd0);
        checkOutput("reset timeout_err", 32'(bus.timeout_err), 32'd0);
        rst = 1'b1;

        $display("[TB] single request");
        setData(2, 8'hA5);
        applyStimulus(4'b0100, 1'b0);
        pushExp(2, 8'hA5);
        tick();
        expectGrant("single", 0, 4'b0100);
        doneAfter("single", 9);

        $display("[TB] round robin");
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) setData(i, DATA_W'(8'h10 + i));
        applyStimulus(4'b1111, 1'b0);
        pushExp(0, 8'h10);
        pushExp(1, 8'h11);
        pushExp(2, 8'h12);
        pushExp(3, 8'h13);
        pushExp(0, 8'h10);
        for (int g = 0; g < 5; g++) begin
            expectGrant("rr", 4, (g == 4) ? 4'b1111 : 4'b0000);
            doneAfter("rr", 3);
        end

        $display("[TB] busy hold-off");
        setData(0, 8'h3C);
        applyStimulus(4'b0001, 1'b1);
        saw = 1'b0;
        repeat (20) begin
            tick();
            if (bus.ack !== '0 || bus.tx_start !== 1'b0) saw = 1'b1;
        end
        checkOutput("busy holdoff", 32'(saw), 32'd0);
        bus.tx_busy = 1'b0;
        pushExp(0, 8'h3C);
        tick();
        expectGrant("busy release", 0, 4'b0001);
        doneAfter("busy release", 2);

        applyStimulus(4'b0100, 1'b1);
        repeat (3) tick();
        applyStimulus(4'b0000, 1'b1);
        tick();
        bus.tx_busy = 1'b0;
        saw = 1'b0;
        repeat (5) begin
            tick();
            if (bus.ack !== '0 || bus.tx_start !== 1'b0) saw = 1'b1;
        end
        checkOutput("withdrawn req", 32'(saw), 32'd0);

        $display("[TB] watchdog");
        setData(1, 8'h77);
        setData(0, 8'h01);
        applyStimulus(4'b0010, 1'b0);
        pushExp(1, 8'h77);
        tick();
        expectGrant("wd", 0, 4'b0010);
        repeat (TIMEOUT) tick();
        checkOutput("wd err early", 32'(bus.timeout_err), 32'd0);
        checkOutput("wd active early", 32'(bus.active), 32'd1);
        tick();
        checkOutput("wd err pulse", 32'(bus.timeout_err), 32'd1);
        checkOutput("wd active cleared", 32'(bus.active), 32'd0);
        applyStimulus(4'b0011, 1'b0);
        pushExp(0, 8'h01);
        tick();
        checkOutput("wd err single", 32'(bus.timeout_err), 32'd0);
        expectGrant("wd next", 0, 4'b0011);
        doneAfter("wd next", 2);

        $display("[TB] back-to-back");
        setData(0, 8'h51);
        applyStimulus(4'b0001, 1'b0);
        pushExp(0, 8'h51);
        tick();
        expectGrant("b2b first", 0, 4'b0000);
        setData(0, 8'h52);
        pushExp(0, 8'h52);
        doneAfter("b2b first", 3);
        checkOutput("b2b idle gap", 32'(bus.tx_start), 32'd0);
        tick();
        expectGrant("b2b second", 0, 4'b0001);
        doneAfter("b2b second", 2);

        $display("[TB] async reset");
        setData(2, 8'h99);
        applyStimulus(4'b0100, 1'b0);
        pushExp(2, 8'h99);
        tick();
        expectGrant("ar frame", 0, 4'b0100);
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("ar active", 32'(bus.active), 32'd0);
        checkOutput("ar tx_data", 32'(bus.tx_data), 32'd0);
        checkOutput("ar grant_idx", 32'(bus.grant_idx), 32'd0);
        setData(3, 8'hC3);
        applyStimulus(4'b1000, 1'b0);
        pushExp(3, 8'hC3);
        tick();
        rst = 1'b1;
        tick();
        expectGrant("ar after", 0, 4'b1000);
        doneAfter("ar after", 2);

        checkOutput("queue drained", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
